// File: rtl/peripheral_spi.sv
// peripheral_spi: memory-mapped SPI master (mode 0, 8-bit, MSB first) on the J1 I/O bus.
module peripheral_spi #(
  parameter int unsigned DEFAULT_DIV = 11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d_in,
  input  logic        cs,
  input  logic [3:0]  addr,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] d_out,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs_n
);

  localparam int unsigned DW = 16;
  localparam int unsigned BW = 8;
  localparam int unsigned PW = 4;

  localparam logic [3:0] A_TXDATA = 4'h0;
  localparam logic [3:0] A_RXDATA = 4'h2;
  localparam logic [3:0] A_STATUS = 4'h4;
  localparam logic [3:0] A_CTRL   = 4'h6;

  typedef enum logic {S_IDLE, S_ACTIVE} state_t;

  state_t          state;
  logic [BW-1:0]   div;
  logic [BW-1:0]   act_div;
  logic [BW-1:0]   hcnt;
  logic [BW-1:0]   sh;
  logic [BW-1:0]   rx_byte;
  logic [PW-1:0]   phase;
  logic            cap;
  logic            done;
  logic            overrun;

  logic            busy_c;
  logic            acc_wr_c;
  logic            acc_rd_c;
  logic [DW-1:0]   rd_data_c;
  logic            unused_d_in;

  // A simultaneous rd and wr is treated as a write only.
  assign busy_c      = (state == S_ACTIVE);
  assign acc_wr_c    = cs & wr;
  assign acc_rd_c    = cs & rd & ~wr;
  assign unused_d_in = ^d_in[15:8];

  // Read-data mux for the register map.
  always_comb begin
    rd_data_c = '0;
    case (addr)
      A_RXDATA: rd_data_c = {8'h00, rx_byte};
      A_STATUS: rd_data_c = {13'b0, overrun, done, busy_c};
      A_CTRL:   rd_data_c = {8'h00, div};
      default:  rd_data_c = '0;
    endcase
  end

  // Bus register access plus the IDLE/ACTIVE transfer engine; later assignments win.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      d_out    <= '0;
      div      <= BW'(DEFAULT_DIV);
      act_div  <= '0;
      hcnt     <= '0;
      sh       <= '0;
      rx_byte  <= '0;
      phase    <= '0;
      cap      <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      spi_sclk <= 1'b0;
      spi_mosi <= 1'b0;
      spi_cs_n <= 1'b1;
    end else begin
      if (acc_rd_c) begin
        d_out <= rd_data_c;
        if (addr == A_RXDATA) done <= 1'b0;
      end

      if (acc_wr_c) begin
        case (addr)
          A_STATUS: begin
            if (d_in[2]) overrun <= 1'b0;
            if (d_in[1]) done    <= 1'b0;
          end
          A_CTRL:  div <= d_in[7:0];
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (acc_wr_c && addr == A_TXDATA) begin
            state    <= S_ACTIVE;
            sh       <= d_in[7:0];
            spi_mosi <= d_in[7];
            spi_cs_n <= 1'b0;
            act_div  <= div;
            hcnt     <= '0;
            phase    <= '0;
          end
        end
        S_ACTIVE: begin
          if (acc_wr_c && addr == A_TXDATA) overrun <= 1'b1;
          if (hcnt == act_div) begin
            hcnt  <= '0;
            phase <= phase + PW'(1);
            if (!phase[0]) begin
              // Rising SCLK: capture slave data.
              spi_sclk <= 1'b1;
              cap      <= spi_miso;
            end else begin
              // Falling SCLK: shift and present the next bit.
              spi_sclk <= 1'b0;
              sh       <= {sh[6:0], cap};
              if (phase == 4'hF) begin
                state    <= S_IDLE;
                rx_byte  <= {sh[6:0], cap};
                done     <= 1'b1;
                spi_cs_n <= 1'b1;
              end else begin
                spi_mosi <= sh[6];
              end
            end
          end else begin
            hcnt <= hcnt + BW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_peripheral_spi.sv
// tb_peripheral_spi: directed self-checking bench for the SPI master peripheral.
module tb_peripheral_spi;

  logic        clk;
  logic        rst;
  logic [15:0] d_in;
  logic        cs;
  logic [3:0]  addr;
  logic        rd;
  logic        wr;
  logic [15:0] d_out;
  logic        spi_sclk;
  logic        spi_mosi;
  logic        spi_miso;
  logic        spi_cs_n;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  peripheral_spi #(.DEFAULT_DIV(11)) dut (
    .clk      (clk),
    .rst      (rst),
    .d_in     (d_in),
    .cs       (cs),
    .addr     (addr),
    .rd       (rd),
    .wr       (wr),
    .d_out    (d_out),
    .spi_sclk (spi_sclk),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .spi_cs_n (spi_cs_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave model: byte slv_tx, MSB first, next bit presented after each SCLK fall.
  logic [7:0] slv_tx = 8'h00;
  logic [2:0] slv_cnt = 3'd0;
  always @(negedge spi_sclk or posedge spi_cs_n) begin
    if (spi_cs_n) slv_cnt = 3'd0;
    else          slv_cnt = slv_cnt + 3'd1;
  end
  assign spi_miso = slv_tx[3'd7 - slv_cnt];

  // Monitors: MOSI at SCLK rises, and cycle counts of CS low / SCLK high.
  logic [7:0]  mosi_cap = 8'h00;
  int unsigned rise_cnt = 0;
  int unsigned low_cnt  = 0;
  int unsigned hi_cnt   = 0;
  always @(posedge spi_sclk) begin
    mosi_cap = {mosi_cap[6:0], spi_mosi};
    rise_cnt++;
  end
  always @(posedge clk) begin
    if (!spi_cs_n) low_cnt++;
    if (spi_sclk)  hi_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [15:0] d, input logic sel);
    @(negedge clk);
    cs = sel; wr = 1'b1; rd = 1'b0; addr = a; d_in = d;
    @(negedge clk);
    cs = 1'b0; wr = 1'b0; d_in = 16'h0;
  endtask

  task automatic bus_read(input logic [3:0] a, input logic sel);
    @(negedge clk);
    cs = sel; rd = 1'b1; wr = 1'b0; addr = a;
    @(negedge clk);
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int unsigned n;
    n = 0;
    while (!spi_cs_n && n < 20000) begin
      @(negedge clk);
      n++;
    end
    if (!spi_cs_n) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed timeout expected frame end", tag);
    end
  endtask

  int unsigned b_low, b_hi, b_rise, n;

  initial begin
    rst = 1'b1; d_in = '0; cs = 1'b0; addr = '0; rd = 1'b0; wr = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_cs_n", 16'(spi_cs_n), 16'h1);
    check("rst_sclk", 16'(spi_sclk), 16'h0);
    check("rst_mosi", 16'(spi_mosi), 16'h0);
    check("rst_dout", d_out, 16'h0000);
    bus_read(4'h4, 1'b1);
    check("rst_status", d_out, 16'h0000);
    bus_read(4'h6, 1'b1);
    check("rst_ctrl", d_out, 16'h000B);
    check("rst_cs_n2", 16'(spi_cs_n), 16'h1);

    // div=0, TX A5, slave returns 3C
    bus_write(4'h6, 16'h0000, 1'b1);
    slv_tx = 8'h3C;
    b_low = low_cnt; b_hi = hi_cnt; b_rise = rise_cnt;
    bus_write(4'h0, 16'h00A5, 1'b1);
    check("a5_start_cs_n", 16'(spi_cs_n), 16'h0);
    check("a5_start_mosi", 16'(spi_mosi), 16'h1);
    wait_idle("a5_frame");
    check("a5_mosi", 16'(mosi_cap), 16'h00A5);
    check("a5_rises", 16'(rise_cnt - b_rise), 16'd8);
    check("a5_cs_low", 16'(low_cnt - b_low), 16'd16);
    check("a5_sclk_hi", 16'(hi_cnt - b_hi), 16'd8);
    bus_read(4'h4, 1'b1);
    check("a5_status_done", d_out, 16'h0002);
    bus_read(4'h2, 1'b1);
    check("a5_rxdata", d_out, 16'h003C);
    bus_read(4'h4, 1'b1);
    check("a5_status_clr", d_out, 16'h0000);

    // div=3, TX FF, slave returns 81
    bus_write(4'h6, 16'h0003, 1'b1);
    slv_tx = 8'h81;
    b_low = low_cnt; b_hi = hi_cnt; b_rise = rise_cnt;
    bus_write(4'h0, 16'h00FF, 1'b1);
    wait_idle("ff_frame");
    check("ff_mosi", 16'(mosi_cap), 16'h00FF);
    check("ff_cs_low", 16'(low_cnt - b_low), 16'd64);
    check("ff_sclk_hi", 16'(hi_cnt - b_hi), 16'd32);
    check("ff_rises", 16'(rise_cnt - b_rise), 16'd8);
    bus_read(4'h2, 1'b1);
    check("ff_rxdata", d_out, 16'h0081);

    // Overrun: TX 11 then TX 22 mid-frame
    slv_tx = 8'h00;
    bus_write(4'h0, 16'h0011, 1'b1);
    repeat (10) @(negedge clk);
    bus_write(4'h0, 16'h0022, 1'b1);
    bus_read(4'h4, 1'b1);
    check("ovr_status_mid", d_out, 16'h0005);
    wait_idle("ovr_frame");
    check("ovr_mosi", 16'(mosi_cap), 16'h0011);
    bus_read(4'h4, 1'b1);
    check("ovr_status_end", d_out, 16'h0006);
    bus_write(4'h4, 16'h0004, 1'b1);
    bus_read(4'h4, 1'b1);
    check("ovr_status_clr", d_out, 16'h0002);
    bus_read(4'h2, 1'b1);
    check("ovr_rxdata", d_out, 16'h0000);

    // Reset pulse at the 5th SCLK rise
    bus_write(4'h6, 16'h0002, 1'b1);
    slv_tx = 8'hC3;
    b_rise = rise_cnt;
    bus_write(4'h0, 16'h005A, 1'b1);
    n = 0;
    while (rise_cnt - b_rise < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_rise5", 16'(rise_cnt - b_rise), 16'd5);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_cs_n", 16'(spi_cs_n), 16'h1);
    check("abort_sclk", 16'(spi_sclk), 16'h0);
    check("abort_dout", d_out, 16'h0000);
    bus_read(4'h4, 1'b1);
    check("abort_status", d_out, 16'h0000);
    bus_read(4'h6, 1'b1);
    check("abort_ctrl", d_out, 16'h000B);
    repeat (3) @(negedge clk);
    check("abort_stays_idle", 16'(spi_cs_n), 16'h1);

    // Unmapped addresses and deselected accesses
    bus_read(4'h8, 1'b1);
    check("addr8_read", d_out, 16'h0000);
    bus_read(4'h6, 1'b1);
    check("ctrl_before_hold", d_out, 16'h000B);
    bus_read(4'hF, 1'b1);
    check("addrF_read", d_out, 16'h0000);
    bus_read(4'h6, 1'b1);
    bus_read(4'h4, 1'b0);
    check("cs0_read_hold", d_out, 16'h000B);
    bus_write(4'h6, 16'h0055, 1'b0);
    bus_write(4'h0, 16'h00AA, 1'b0);
    bus_write(4'h8, 16'h00FF, 1'b1);
    repeat (3) @(negedge clk);
    check("cs0_tx_no_start", 16'(spi_cs_n), 16'h1);
    bus_read(4'h6, 1'b1);
    check("cs0_ctrl_unchanged", d_out, 16'h000B);
    bus_read(4'h4, 1'b1);
    check("cs0_status_unchanged", d_out, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/peripheral_spi.md
# peripheral_spi

Memory-mapped SPI master on the J1 I/O bus. It responds to CPU reads and writes through the SoC address decoder's chip-select, using the same `d_in`/`d_out`/`addr`/`rd`/`wr` contract as the multiplier, divider and UART peripherals. It drives one SPI slave in mode 0 (CPOL=0, CPHA=0), 8-bit frames, MSB first. It is intended for chip-select slot `8'h70` of the decoder.

## Interface
Parameters:
- `DEFAULT_DIV`, default 11: reset value of the clock divider. At 25 MHz this gives ~1.04 MHz SCLK.

Ports (name, direction, width, meaning):
- `clk`  in  1  system clock.
- `rst`  in  1  reset. Synchronous and active-high: it is sampled on the rising edge of `clk`.
- `d_in`  in  16  write data from the CPU (`j1_io_dout`).
- `cs`  in  1  chip-select from the address decoder.
- `addr`  in  4  register select (`j1_io_addr[3:0]`).
- `rd`  in  1  CPU read strobe.
- `wr`  in  1  CPU write strobe.
- `d_out`  out  16  registered read data.
- `spi_sclk`  out  1  SPI clock. Idles low.
- `spi_mosi`  out  1  master data out.
- `spi_miso`  in  1  slave data in. Assumed synchronous to `clk`; no synchronizer is needed.
- `spi_cs_n`  out  1  slave select, active-low.

## Operation
Register map (`addr`):
- `4'h0` TXDATA, write-only. A write of `d_in[7:0]` starts a transfer.
- `4'h2` RXDATA, read-only. Reads return `{8'h00, rx_byte}`.
- `4'h4` STATUS:
  - Reads return `{13'b0, overrun, done, busy}`.
  - Writing a 1 to `d_in[2]` clears `overrun`; writing a 1 to `d_in[1]` clears `done`.
- `4'h6` CTRL, read/write. `div[7:0]` = `d_in[7:0]`; reads return `{8'h00, div}`.
- Any other address: writes are ignored and reads return `16'h0000`.

Access rules:
- An access happens only when `cs` is high. `rd` and `wr` both high in the same cycle counts as a write.
- `d_out` is updated only on a cycle with `cs & rd`; at all other times it holds its value.
- TXDATA write while `busy`=0: the byte is accepted, `div` is latched into the active divider, and `busy` is set.
- TXDATA write while `busy`=1: the data is discarded, `overrun` is set, and the transfer in progress is not disturbed.
- CTRL writes during a transfer update `div`, but the new value affects only the next transfer.

State machine IDLE → ACTIVE → IDLE:
- IDLE:
  - `spi_cs_n`=1, `spi_sclk`=0, `busy`=0.
  - `spi_mosi` holds the last driven bit (0 after reset).
- ACTIVE:
  - Shift register `sh[7:0]` is loaded with the TX byte; `spi_mosi`=`sh[7]`.
  - A half-period counter counts `div+1` clocks per half period.
  - 16 half periods in total; a 4-bit phase counter tracks them.
  - Even→odd phase transition: `spi_sclk` rises and `spi_miso` is sampled into a capture bit.
  - Odd→even phase transition: `spi_sclk` falls, `sh` shifts left with the capture bit entering bit 0, and `spi_mosi` takes the new `sh[7]`.
- After the 16th half period (the 8th falling edge), the FSM returns to IDLE:
  - `rx_byte` ← `sh`, `done` ← 1, `busy` ← 0, `spi_cs_n` ← 1. All of these happen in the same cycle.

Status-flag behaviour:
- `done` is cleared by a RXDATA read or by a STATUS write with bit 1 set.
- If transfer completion and a `done`-clear occur in the same cycle, set wins and `d_out` returns the old `rx_byte`.
- `overrun` being set has no other side effect.

## Timing
- Reset, effective at the first rising edge with `rst`=1:
  - `d_out`=0, `spi_sclk`=0, `spi_mosi`=0, `spi_cs_n`=1.
  - `busy`=`done`=`overrun`=0, `rx_byte`=0, `div`=`DEFAULT_DIV`, FSM in IDLE.
- Reset asserted mid-transfer aborts it: at the next edge the outputs take their reset values, and no `done` is set.
- Read latency: `d_out` is valid one clock after the edge that samples `cs & rd`.
- Start latency, for a TXDATA write sampled at edge T0:
  - At T0+1: `spi_cs_n`=0, `spi_mosi`=bit 7, `busy`=1.
  - The first `spi_sclk` rise is at T0+1+(`div`+1).
- Frame length: `spi_cs_n` stays low for exactly 16·(`div`+1) clocks. At the edge it rises, `busy`=0 and `done`=1.
- `div`=0 gives SCLK = clk/2, the fastest rate. `div`=255 gives 512 clocks per bit.
- Back-to-back transfers: a TXDATA write accepted in the first IDLE cycle gives one clock of `spi_cs_n` high between frames.

## Test plan
- Reset, then read STATUS and CTRL → `d_out`=`16'h0000` and `16'h000B`; `spi_cs_n`=1 and `spi_sclk`=0 throughout.
- CTRL=0, TXDATA=`8'hA5`, slave model returns `8'h3C` → MOSI bits 1,0,1,0,0,1,0,1 appear on rising edges; `spi_cs_n` is low for 16 clocks; RXDATA=`16'h003C`; STATUS=`16'h0002` after the frame and `16'h0000` after the RXDATA read.
- CTRL=3, TXDATA=`8'hFF` → SCLK half period is 4 clocks; `spi_cs_n` is low for 64 clocks.
- TXDATA=`8'h11`, then TXDATA=`8'h22` mid-frame → MOSI carries only `8'h11`; STATUS=`16'h0005`; after the frame, a STATUS write of `16'h0004` leaves `16'h0002`.
- `rst` pulsed for one cycle at the 5th SCLK rise → next cycle `spi_cs_n`=1, `spi_sclk`=0, STATUS=0, `div`=11.
- Reads at addresses `4'h8`/`4'hF`, and any access with `cs`=0 → no state change; `d_out`=0 for `4'h8`/`4'hF` reads and holds its previous value for `cs`=0 accesses.
